// File: rtl/mult_16.sv
// Sequential shift-and-add unsigned multiplier with an IDLE/ITER/DONE handshake FSM.
// One add/shift step per clock; the product lands in R on the edge that enters DONE.
module mult_16 #(
  parameter int WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 init_in,
  input  logic [WIDTH-1:0]     A,
  input  logic [WIDTH-1:0]     B,
  output logic [2*WIDTH-1:0]   R,
  output logic                 done,
  output logic                 busy
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state;
  state_t             state_next;
  logic [2*WIDTH-1:0] md;
  logic [2*WIDTH-1:0] pp;
  logic [2*WIDTH-1:0] pp_sum;
  logic [WIDTH-1:0]   mr;
  logic [CW-1:0]      cnt;
  logic               last_step;

  // The final step's add must be folded into R, so R takes pp_sum rather than pp.
  assign pp_sum    = pp + (mr[0] ? md : '0);
  assign last_step = (cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    done       = 1'b0;
    busy       = 1'b0;
    case (state)
      IDLE: begin
        if (init_in) begin
          state_next = ITER;
        end
      end
      ITER: begin
        busy = 1'b1;
        if (last_step) begin
          state_next = DONE;
        end
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      md  <= '0;
      mr  <= '0;
      pp  <= '0;
      cnt <= '0;
      R   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (init_in) begin
            md  <= {{WIDTH{1'b0}}, A};
            mr  <= B;
            pp  <= '0;
            cnt <= '0;
          end
        end
        ITER: begin
          pp  <= pp_sum;
          md  <= md << 1;
          mr  <= mr >> 1;
          cnt <= cnt + CW'(1);
          if (last_step) begin
            R <= pp_sum;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mult_16.sv
// Directed self-checking bench for mult_16: latency, products, reset abort, back-to-back starts.
module tb_mult_16;

  logic        clk;
  logic        rst;
  logic        init_in;
  logic [15:0] A;
  logic [15:0] B;
  logic [31:0] R;
  logic        done;
  logic        busy;

  int n_checks;
  int n_fail;

  mult_16 #(.WIDTH(16)) dut (
    .clk     (clk),
    .rst     (rst),
    .init_in (init_in),
    .A       (A),
    .B       (B),
    .R       (R),
    .done    (done),
    .busy    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Starts one operation from IDLE and follows it to its done pulse.
  // Edge 1 is the start edge, so done must appear after edge 17.
  task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input logic [31:0] exp, input int hold);
    int          edges;
    int          busy_cycles;
    int          r_changes;
    bit          seen;
    logic [31:0] r_prev;
    edges       = 0;
    busy_cycles = 0;
    r_changes   = 0;
    seen        = 1'b0;
    r_prev      = R;
    A           = a;
    B           = b;
    init_in     = 1'b1;
    while (!seen && edges < 40) begin
      tick();
      edges++;
      if (edges == 1) begin
        A = ~a;
        B = ~b;
      end
      if (edges >= hold) init_in = 1'b0;
      if (busy) busy_cycles++;
      if (done) seen = 1'b1;
      else if (R !== r_prev) r_changes++;
    end
    check_output({tag, "_done_seen"}, 64'(seen), 64'd1);
    check_output({tag, "_latency"}, 64'(edges), 64'd17);
    check_output({tag, "_busy_cycles"}, 64'(busy_cycles), 64'd16);
    check_output({tag, "_product"}, 64'(R), 64'(exp));
    check_output({tag, "_r_stable"}, 64'(r_changes), 64'd0);
    tick();
    check_output({tag, "_done_single"}, 64'(done), 64'd0);
    check_output({tag, "_idle_busy"}, 64'(busy), 64'd0);
    check_output({tag, "_r_hold"}, 64'(R), 64'(exp));
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int          done_count;
    int          done_edges[3];
    int          busy_seen;
    logic [15:0] quotient;

    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b1;
    init_in  = 1'b0;
    A        = 16'h0000;
    B        = 16'h0000;

    tick();
    tick();
    rst = 1'b0;
    check_output("reset_R", 64'(R), 64'd0);
    check_output("reset_done", 64'(done), 64'd0);
    check_output("reset_busy", 64'(busy), 64'd0);

    run_op("m52x9", 16'h0052, 16'h0009, 32'h000002E2, 2);

    // Stand-in for the divider: restoring division of R[15:0] by 9 must give back 0x52.
    quotient = R[15:0] / 16'h0009;
    check_output("roundtrip_quotient", 64'(quotient), 64'h52);

    run_op("ffff_sq", 16'hFFFF, 16'hFFFF, 32'hFFFE0001, 1);

    // Abort at iteration 8: the partial product must vanish and R must clear.
    A       = 16'h0100;
    B       = 16'h0100;
    init_in = 1'b1;
    tick();
    init_in = 1'b0;
    repeat (7) tick();
    check_output("abort_busy_before", 64'(busy), 64'd1);
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    check_output("abort_R", 64'(R), 64'd0);
    check_output("abort_busy", 64'(busy), 64'd0);
    check_output("abort_done", 64'(done), 64'd0);
    done_count = 0;
    busy_seen  = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (done) done_count++;
      if (busy) busy_seen++;
    end
    check_output("abort_no_done", 64'(done_count), 64'd0);
    check_output("abort_stays_idle", 64'(busy_seen), 64'd0);

    run_op("m3x5", 16'h0003, 16'h0005, 32'h0000000F, 1);
    run_op("b_zero", 16'h1234, 16'h0000, 32'h00000000, 1);
    run_op("a_zero", 16'h0000, 16'hFFFF, 32'h00000000, 1);

    // Back-to-back with init_in held: starts at edges 1, 19, 37; done after 17, 35, 53.
    A          = 16'h0007;
    B          = 16'h0006;
    init_in    = 1'b1;
    done_count = 0;
    for (int k = 1; k <= 60; k++) begin
      tick();
      if (k == 22) A = 16'h0008;
      if (k == 28) A = 16'h0007;
      if (done) begin
        if (done_count < 3) done_edges[done_count] = k;
        done_count++;
        check_output("b2b_product", 64'(R), 64'h2A);
      end
    end
    init_in = 1'b0;
    check_output("b2b_done_count", 64'(done_count), 64'd3);
    check_output("b2b_done_edge0", 64'(done_edges[0]), 64'd17);
    check_output("b2b_done_edge1", 64'(done_edges[1]), 64'd35);
    check_output("b2b_done_edge2", 64'(done_edges[2]), 64'd53);
    repeat (20) tick();
    check_output("b2b_final_R", 64'(R), 64'h2A);
    check_output("b2b_final_busy", 64'(busy), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
